sd_spi_init_controller: RTL

SD_SPI_INIT_CONTROLLER -- requirements
Module: sd_spi_init_controller

---
 rtl/sd_spi_init_controller.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_init_controller.sv
// ---------------------------------------------------------------------------
// sd_spi_init_controller
//
// Brings an SD card from power-up into SPI mode and runs the standard
// initialisation handshake: 80 dummy clocks with CS high, then
// CMD0 -> CMD8 -> (CMD55 -> ACMD41)* until the card leaves idle state.
// The result is reported through sticky done/error flags, a 3-bit error
// code and a flag telling whether the card answered CMD8 as an SDv2 card.
//
// The SPI link runs in mode 0 (SCLK idle low, MOSI changes on the falling
// edge, MISO sampled on the rising edge). Every byte takes exactly
// 16*HALF_PERIOD system clocks and bytes follow each other with no gap.
//
// Parameters
//   HALF_PERIOD     system clocks per SCLK half period
//   ACMD41_RETRIES  CMD55/ACMD41 pairs allowed before giving up
//
// Ports
//   current_clock_signal  system clock, rising edge
//   reset_n               asynchronous active-low reset
//   start                 one-cycle request to run the sequence (ignored while busy)
//   miso                  card data out
//   sclk                  SPI clock to the card
//   mosi                  card data in, MSB first
//   cs_n                  card chip select, active low
//   busy                  sequence in progress
//   init_done             sticky success flag
//   init_error            sticky failure flag
//   error_code            0 none, 1 CMD0 bad R1, 2 CMD8 fault,
//                         3 ACMD41 retries exhausted, 4 R1 timeout / bad R1
//   card_v2               card answered CMD8 with R1=0x01 and echo 0x1AA
// ---------------------------------------------------------------------------
module sd_spi_init_controller #(
    parameter int HALF_PERIOD    = 15,
    parameter int ACMD41_RETRIES = 255
) (
    input  logic       current_clock_signal,
    input  logic       reset_n,
    input  logic       start,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       init_done,
    output logic       init_error,
    output logic [2:0] error_code,
    output logic       card_v2
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DUMMY     = 3'd1;
    localparam logic [2:0] SEND_CMD  = 3'd2;
    localparam logic [2:0] WAIT_R1   = 3'd3;
    localparam logic [2:0] READ_TAIL = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] ERROR     = 3'd7;

    localparam logic [1:0] CMD0   = 2'd0;
    localparam logic [1:0] CMD8   = 2'd1;
    localparam logic [1:0] CMD55  = 2'd2;
    localparam logic [1:0] ACMD41 = 2'd3;

    localparam int              HW          = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0]   HALF_LAST   = HW'(HALF_PERIOD - 1);
    localparam logic [7:0]      RETRY_LIMIT = 8'(ACMD41_RETRIES);

    logic [2:0]    state;
    logic [1:0]    cmd;
    logic [HW-1:0] half_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    byte_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic [7:0]    retry_cnt;
    logic          tail_ok;

    logic shifting;
    logic half_tick;

    // Six-byte command frames (command, 32-bit argument, CRC+stop bit).
    // The CRC bytes are the real ones so a card that checks CRC in SPI mode
    // still accepts CMD0 and CMD8.
    function automatic logic [7:0] cmd_byte(input logic [1:0] c, input logic [2:0] idx);
        logic [47:0] frame;
        case (c)
            CMD0:    frame = 48'h40_00_00_00_00_95;
            CMD8:    frame = 48'h48_00_00_01_AA_87;
            CMD55:   frame = 48'h77_00_00_00_00_65;
            default: frame = 48'h69_40_00_00_00_77;
        endcase
        case (idx)
            3'd0:    cmd_byte = frame[47:40];
            3'd1:    cmd_byte = frame[39:32];
            3'd2:    cmd_byte = frame[31:24];
            3'd3:    cmd_byte = frame[23:16];
            3'd4:    cmd_byte = frame[15:8];
            default: cmd_byte = frame[7:0];
        endcase
    endfunction

    // The byte engine runs in every state that talks to the card; the
    // remaining states (IDLE, DONE, ERROR) are the "not busy" states.
    assign shifting  = (state == DUMMY) || (state == SEND_CMD) || (state == WAIT_R1) ||
                       (state == READ_TAIL) || (state == GAP);
    assign half_tick = (half_cnt == HALF_LAST);

    // Chip select is low only while a command or its response is on the
    // wire; the dummy clocks and the inter-command gap byte run with CS high.
    // MOSI idles high, and during shifting it is the MSB of the transmit
    // register, which is reloaded on the last falling edge of each byte so
    // the next byte's first bit is present before its first rising edge.
    assign busy = shifting;
    assign cs_n = !((state == SEND_CMD) || (state == WAIT_R1) || (state == READ_TAIL));
    assign mosi = shifting ? tx_sr[7] : 1'b1;

    // Byte engine and command sequencer. SCLK toggles every HALF_PERIOD
    // clocks; the rising edge samples MISO, the falling edge shifts MOSI.
    // The falling edge of bit 7 is the byte boundary: at that point rx_sr
    // holds the complete received byte and the FSM decides what goes next,
    // so consecutive bytes are back-to-back. Leaving to DONE or ERROR also
    // happens on a falling edge, which parks SCLK low.
    always_ff @(posedge current_clock_signal or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd        <= CMD0;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            tx_sr      <= 8'hFF;
            rx_sr      <= 8'hFF;
            retry_cnt  <= '0;
            tail_ok    <= 1'b0;
            sclk       <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            error_code <= 3'd0;
            card_v2    <= 1'b0;
        end else if (!shifting) begin
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= 8'hFF;
            if (start) begin
                state      <= DUMMY;
                cmd        <= CMD0;
                byte_cnt   <= '0;
                retry_cnt  <= '0;
                init_done  <= 1'b0;
                init_error <= 1'b0;
                error_code <= 3'd0;
                card_v2    <= 1'b0;
            end
        end else if (!half_tick) begin
            half_cnt <= half_cnt + 1'b1;
        end else begin
            half_cnt <= '0;
            sclk     <= ~sclk;
            if (!sclk) begin
                rx_sr <= {rx_sr[6:0], miso};
            end else if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sr   <= {tx_sr[6:0], 1'b1};
            end else begin
                bit_cnt <= 3'd0;
                tx_sr   <= 8'hFF;
                case (state)
                    DUMMY: begin
                        if (byte_cnt == 4'd9) begin
                            state    <= SEND_CMD;
                            byte_cnt <= '0;
                            tx_sr    <= cmd_byte(cmd, 3'd0);
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    SEND_CMD: begin
                        if (byte_cnt == 4'd5) begin
                            state    <= WAIT_R1;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                            tx_sr    <= cmd_byte(cmd, byte_cnt[2:0] + 3'd1);
                        end
                    end
                    WAIT_R1: begin
                        if (!rx_sr[7]) begin
                            byte_cnt <= '0;
                            case (cmd)
                                CMD0: begin
                                    if (rx_sr == 8'h01) begin
                                        state <= GAP;
                                        cmd   <= CMD8;
                                    end else begin
                                        state      <= ERROR;
                                        init_error <= 1'b1;
                                        error_code <= 3'd1;
                                    end
                                end
                                CMD8: begin
                                    if (rx_sr == 8'h01) begin
                                        state   <= READ_TAIL;
                                        tail_ok <= 1'b1;
                                    end else if (rx_sr == 8'h05) begin
                                        state <= GAP;
                                        cmd   <= CMD55;
                                    end else begin
                                        state      <= ERROR;
                                        init_error <= 1'b1;
                                        error_code <= 3'd2;
                                    end
                                end
                                CMD55: begin
                                    if ((rx_sr == 8'h00) || (rx_sr == 8'h01)) begin
                                        state <= GAP;
                                        cmd   <= ACMD41;
                                    end else begin
                                        state      <= ERROR;
                                        init_error <= 1'b1;
                                        error_code <= 3'd4;
                                    end
                                end
                                default: begin
                                    if (rx_sr == 8'h00) begin
                                        state     <= DONE;
                                        init_done <= 1'b1;
                                    end else if (rx_sr == 8'h01) begin
                                        if ((retry_cnt + 8'd1) == RETRY_LIMIT) begin
                                            state      <= ERROR;
                                            init_error <= 1'b1;
                                            error_code <= 3'd3;
                                        end else begin
                                            state <= GAP;
                                            cmd   <= CMD55;
                                        end
                                        retry_cnt <= retry_cnt + 8'd1;
                                    end else begin
                                        state      <= ERROR;
                                        init_error <= 1'b1;
                                        error_code <= 3'd4;
                                    end
                                end
                            endcase
                        end else if (byte_cnt == 4'd7) begin
                            state      <= ERROR;
                            init_error <= 1'b1;
                            error_code <= 3'd4;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    READ_TAIL: begin
                        // The R7 tail is 4 bytes; only the voltage-accepted
                        // byte (index 2) and the check pattern (index 3)
                        // are checked.
                        if ((byte_cnt == 4'd2) && (rx_sr != 8'h01)) begin
                            tail_ok <= 1'b0;
                        end
                        if (byte_cnt == 4'd3) begin
                            byte_cnt <= '0;
                            if (tail_ok && (rx_sr == 8'hAA)) begin
                                state   <= GAP;
                                cmd     <= CMD55;
                                card_v2 <= 1'b1;
                            end else begin
                                state      <= ERROR;
                                init_error <= 1'b1;
                                error_code <= 3'd2;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    GAP: begin
                        state    <= SEND_CMD;
                        byte_cnt <= '0;
                        tx_sr    <= cmd_byte(cmd, 3'd0);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
